mem_arbiter: RTL and testbench

//   Shares the single external SRAM between instruction fetch (IF) and the MEM-stage

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single external SRAM between instruction fetch and the MEM-stage
// data port, sequencing chip/output/write strobes with a fixed wait-state count.
module mem_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INST_RD,
        S_DATA_RD,
        S_DATA_WR,
        S_WR_REC,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_src_mem;
    logic              w_src_mem_next;

    logic              w_grant;
    logic              w_grant_wr;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_capture;
    logic              w_ce_act;
    logic              w_oe_act;
    logic              w_we_act;
    logic              w_dq_act;

    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_dq_oe;

    // Next-state, grant and capture decode
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_src_mem_next = r_src_mem;
        w_grant        = 1'b0;
        w_grant_wr     = 1'b0;
        w_grant_addr   = if_addr_i;
        w_capture      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (mem_req_i) begin
                    w_grant        = 1'b1;
                    w_grant_wr     = mem_we_i;
                    w_grant_addr   = mem_addr_i;
                    w_src_mem_next = 1'b1;
                    w_cnt_next     = CNT_LOAD;
                    w_state_next   = mem_we_i ? S_DATA_WR : S_DATA_RD;
                end else if (if_req_i) begin
                    w_grant        = 1'b1;
                    w_grant_addr   = if_addr_i;
                    w_src_mem_next = 1'b0;
                    w_cnt_next     = CNT_LOAD;
                    w_state_next   = S_INST_RD;
                end
            end
            S_INST_RD, S_DATA_RD: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_DATA_WR: begin
                if (r_cnt == '0) begin
                    w_state_next = S_WR_REC;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_WR_REC: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so pins change cleanly on the edge
    always_comb begin
        w_ce_act = (w_state_next == S_INST_RD) || (w_state_next == S_DATA_RD) ||
                   (w_state_next == S_DATA_WR) || (w_state_next == S_WR_REC);
        w_oe_act = (w_state_next == S_INST_RD) || (w_state_next == S_DATA_RD);
        w_we_act = (w_state_next == S_DATA_WR);
        w_dq_act = (w_state_next == S_DATA_WR) || (w_state_next == S_WR_REC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_src_mem    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_data    <= '0;
            r_mem_rdata  <= '0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_src_mem <= w_src_mem_next;
            r_ce_n    <= ~w_ce_act;
            r_oe_n    <= ~w_oe_act;
            r_we_n    <= ~w_we_act;
            r_dq_oe   <= w_dq_act;
            r_if_ack  <= (w_state_next == S_DONE) && !w_src_mem_next;
            r_mem_ack <= (w_state_next == S_DONE) && w_src_mem_next;
            if (w_grant) begin
                r_sram_addr <= w_grant_addr;
            end
            if (w_grant_wr) begin
                r_sram_wdata <= mem_wdata_i;
            end
            // Read data registers hold until the next capture for the same port
            if (w_capture && r_src_mem) begin
                r_mem_rdata <= sram_rdata_i;
            end
            if (w_capture && !r_src_mem) begin
                r_if_data <= sram_rdata_i;
            end
        end
    end

    assign if_data_o    = r_if_data;
    assign if_ack_o     = r_if_ack;
    assign mem_rdata_o  = r_mem_rdata;
    assign mem_ack_o    = r_mem_ack;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;
    assign sram_dq_oe_o = r_dq_oe;
    assign sram_ce_n_o  = r_ce_n;
    assign sram_oe_n_o  = r_oe_n;
    assign sram_we_n_o  = r_we_n;

    // Released in the ack cycle so the pipeline advances exactly once per access
    assign stall_o = (mem_req_i & ~r_mem_ack) | (if_req_i & ~r_if_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed SRAM scenarios plus randomized traffic
// scored against a transaction-level latency/data model.
module tb_mem_arbiter;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;

    // DUT with WAIT_CYCLES=2
    logic        if_req_i, if_ack_o, mem_req_i, mem_we_i, mem_ack_o, stall_o;
    logic [17:0] if_addr_i, mem_addr_i, sram_addr_o;
    logic [15:0] if_data_o, mem_wdata_i, mem_rdata_o, sram_wdata_o, sram_rdata_i;
    logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;

    // DUT with WAIT_CYCLES=1
    logic        d1_if_req, d1_if_ack, d1_mem_req, d1_mem_we, d1_mem_ack, d1_stall;
    logic [17:0] d1_if_addr, d1_mem_addr, d1_sram_addr;
    logic [15:0] d1_if_data, d1_mem_wdata, d1_mem_rdata, d1_sram_wdata, d1_sram_rdata;
    logic        d1_dq_oe, d1_ce_n, d1_oe_n, d1_we_n;

    logic [15:0] sram [0:262143];
    logic [15:0] model_mem [int];

    mem_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .stall_o(stall_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
        .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o)
    );

    mem_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(d1_if_req), .if_addr_i(d1_if_addr), .if_data_o(d1_if_data), .if_ack_o(d1_if_ack),
        .mem_req_i(d1_mem_req), .mem_we_i(d1_mem_we), .mem_addr_i(d1_mem_addr),
        .mem_wdata_i(d1_mem_wdata), .mem_rdata_o(d1_mem_rdata), .mem_ack_o(d1_mem_ack),
        .stall_o(d1_stall), .sram_addr_o(d1_sram_addr), .sram_wdata_o(d1_sram_wdata),
        .sram_rdata_i(d1_sram_rdata), .sram_dq_oe_o(d1_dq_oe), .sram_ce_n_o(d1_ce_n),
        .sram_oe_n_o(d1_oe_n), .sram_we_n_o(d1_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: reads drive the bus only while output-enabled
    assign sram_rdata_i  = (!sram_ce_n_o && !sram_oe_n_o) ? sram[sram_addr_o] : 16'h0000;
    assign d1_sram_rdata = (!d1_ce_n && !d1_oe_n) ? sram[d1_sram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) begin
            sram[sram_addr_o] <= sram_wdata_o;
        end
    end

    // Bus-contention rules checked every cycle
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (!sram_ce_n_o && !sram_oe_n_o && !sram_we_n_o) begin
                failures++;
                $display("FAIL proto_oe_we got ce_n=%b oe_n=%b we_n=%b exp not all low", sram_ce_n_o, sram_oe_n_o, sram_we_n_o);
            end
            checks++;
            if (sram_dq_oe_o && !sram_oe_n_o) begin
                failures++;
                $display("FAIL proto_dq_oe got dq_oe=%b oe_n=%b exp no overlap", sram_dq_oe_o, sram_oe_n_o);
            end
        end
    end

    function automatic logic [15:0] rd_model(input logic [17:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        sram[a] = d;
        model_mem[int'(a)] = d;
    endtask

    // One arbitration episode on the W=2 DUT; expected ack cycles come from the latency rules
    task automatic run_txn(input bit do_if, input bit do_mem, input bit we,
                           input logic [17:0] maddr, input logic [15:0] wd,
                           input logic [17:0] iaddr, input bit scramble, input string tag);
        int t_mem, t_if, oe_cnt, we_cnt, hold_cnt, exp_oe, exp_we, exp_hold;
        logic [15:0] exp_m, exp_i;
        bit mem_pend, if_pend, exp_stall;
        exp_m = 16'h0000;
        t_mem = -1;
        if (do_mem) begin
            t_mem = we ? W + 2 : W + 1;
            if (we) model_mem[int'(maddr)] = wd;
            else exp_m = rd_model(maddr);
        end
        t_if  = do_if ? (do_mem ? t_mem + 1 + W + 1 : W + 1) : -1;
        exp_i = rd_model(iaddr);
        exp_oe   = ((do_mem && !we) ? W : 0) + (do_if ? W : 0);
        exp_we   = (do_mem && we) ? W : 0;
        exp_hold = (do_mem && we) ? 1 : 0;
        oe_cnt = 0; we_cnt = 0; hold_cnt = 0;

        @(negedge clk);
        mem_req_i = do_mem; mem_we_i = we; mem_addr_i = maddr; mem_wdata_i = wd;
        if_req_i = do_if; if_addr_i = iaddr;
        mem_pend = do_mem; if_pend = do_if;
        for (int t = 1; t <= 20 && (mem_pend || if_pend); t++) begin
            @(negedge clk);
            checks++;
            if (mem_ack_o !== (mem_pend && t == t_mem)) begin
                failures++;
                $display("FAIL %s mem_ack cycle %0d got=%b exp=%b", tag, t, mem_ack_o, (mem_pend && t == t_mem));
            end
            checks++;
            if (if_ack_o !== (if_pend && t == t_if)) begin
                failures++;
                $display("FAIL %s if_ack cycle %0d got=%b exp=%b", tag, t, if_ack_o, (if_pend && t == t_if));
            end
            exp_stall = (mem_pend && t != t_mem) || (if_pend && t != t_if);
            checks++;
            if (stall_o !== exp_stall) begin
                failures++;
                $display("FAIL %s stall cycle %0d got=%b exp=%b", tag, t, stall_o, exp_stall);
            end
            if (!sram_oe_n_o) oe_cnt++;
            if (!sram_we_n_o) we_cnt++;
            if (sram_we_n_o && !sram_ce_n_o && sram_dq_oe_o) hold_cnt++;
            if (t == t_mem) begin
                if (!we) begin
                    checks++;
                    if (mem_rdata_o !== exp_m) begin
                        failures++;
                        $display("FAIL %s mem_rdata addr=%h got=%h exp=%h", tag, maddr, mem_rdata_o, exp_m);
                    end
                end
                mem_pend = 1'b0;
                mem_req_i = 1'b0;
            end
            if (t == t_if) begin
                checks++;
                if (if_data_o !== exp_i) begin
                    failures++;
                    $display("FAIL %s if_data addr=%h got=%h exp=%h", tag, iaddr, if_data_o, exp_i);
                end
                if_pend = 1'b0;
                if_req_i = 1'b0;
            end
            if (scramble && mem_pend) begin
                mem_addr_i = 18'($urandom_range(0, 63));
                mem_we_i = 1'($urandom_range(0, 1));
                mem_wdata_i = 16'($urandom);
            end
            if (scramble && if_pend && !do_mem) if_addr_i = 18'($urandom_range(0, 63));
        end
        checks++;
        if (oe_cnt != exp_oe || we_cnt != exp_we || hold_cnt != exp_hold) begin
            failures++;
            $display("FAIL %s strobe_counts got oe=%0d we=%0d hold=%0d exp oe=%0d we=%0d hold=%0d",
                     tag, oe_cnt, we_cnt, hold_cnt, exp_oe, exp_we, exp_hold);
        end
        $display("txn %s if=%0b mem=%0b we=%0b maddr=%h iaddr=%h", tag, do_if, do_mem, we, maddr, iaddr);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req_i = 1'b1; if_addr_i = 18'h00123;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 18'h00456; mem_wdata_i = 16'hA5A5;
        repeat (3) @(negedge clk);
        checks++;
        if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o, if_ack_o, mem_ack_o} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_strobes got ce/oe/we/dq/ifack/memack=%b exp=111000",
                     {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o, if_ack_o, mem_ack_o});
        end
        checks++;
        if ({sram_addr_o, sram_wdata_o, if_data_o, mem_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h ifd=%h memd=%h exp=0",
                     sram_addr_o, sram_wdata_o, if_data_o, mem_rdata_o);
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sram_ce_n_o !== 1'b1 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got ce_n=%b stall=%b exp ce_n=1 stall=0", sram_ce_n_o, stall_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 18'h00100; mem_wdata_i = 16'h5555;
        @(negedge clk);
        checks++;
        if (sram_we_n_o !== 1'b0) begin
            failures++;
            $display("FAIL midwr_started got we_n=%b exp=0", sram_we_n_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sram_we_n_o, sram_dq_oe_o, sram_ce_n_o, mem_ack_o} !== 4'b1010) begin
            failures++;
            $display("FAIL midwr_abort got we_n/dq_oe/ce_n/ack=%b exp=1010",
                     {sram_we_n_o, sram_dq_oe_o, sram_ce_n_o, mem_ack_o});
        end
        mem_req_i = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_ack_o !== 1'b0 || sram_ce_n_o !== 1'b1) begin
                failures++;
                $display("FAIL midwr_noack got ack=%b ce_n=%b exp ack=0 ce_n=1", mem_ack_o, sram_ce_n_o);
            end
        end
        $display("txn reset mid-write done");
        run_txn(1'b0, 1'b1, 1'b0, 18'h00010, 16'h0, 18'h0, 1'b0, "after_reset_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 3);
            run_txn(op != 1, op != 0, 1'($urandom_range(0, 1)),
                    18'($urandom_range(0, 63)), 16'($urandom),
                    18'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back_wait1();
        int idx, next_ack;
        logic [15:0] exp_d;
        idx = 0;
        next_ack = 2;
        @(negedge clk);
        d1_if_req = 1'b1; d1_if_addr = 18'h0;
        for (int t = 1; t <= 12 && idx < 3; t++) begin
            @(negedge clk);
            checks++;
            if (d1_if_ack !== (t == next_ack)) begin
                failures++;
                $display("FAIL b2b_ack cycle %0d got=%b exp=%b", t, d1_if_ack, (t == next_ack));
            end
            checks++;
            if (d1_stall !== (t != next_ack)) begin
                failures++;
                $display("FAIL b2b_stall cycle %0d got=%b exp=%b", t, d1_stall, (t != next_ack));
            end
            if (t == next_ack) begin
                exp_d = rd_model(18'(idx));
                checks++;
                if (d1_if_data !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_data idx=%0d got=%h exp=%h", idx, d1_if_data, exp_d);
                end
                $display("txn b2b fetch addr=%0d data=%h", idx, d1_if_data);
                idx++;
                next_ack += 3;
                if (idx < 3) d1_if_addr = 18'(idx);
                else d1_if_req = 1'b0;
            end
        end
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", idx);
        end
        d1_if_req = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0;
        d1_if_req = 1'b0; d1_if_addr = '0; d1_mem_req = 1'b0; d1_mem_we = 1'b0;
        d1_mem_addr = '0; d1_mem_wdata = '0;
        for (int a = 0; a < 64; a++) preload(18'(a), 16'($urandom));
        preload(18'h00010, 16'h4A12);
        preload(18'h00020, 16'h1234);
        preload(18'h3FFFF, 16'h0000);

        test_reset();
        run_txn(1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 18'h00010, 1'b0, "if_read");
        run_txn(1'b0, 1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 18'h0, 1'b0, "data_write");
        run_txn(1'b0, 1'b1, 1'b0, 18'h3FFFF, 16'h0, 18'h0, 1'b0, "readback");
        run_txn(1'b1, 1'b1, 1'b0, 18'h00020, 16'h0, 18'h00010, 1'b0, "conflict");
        run_txn(1'b1, 1'b1, 1'b1, 18'h00005, 16'h7E57, 18'h00005, 1'b1, "conflict_wr");
        test_reset_mid_write();
        test_random();
        test_back_to_back_wait1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
